processing_element: RTL and testbench

// - Output-stationary multiply-accumulate cell for an 8-bit systolic array.
// - Mode 0 (compute): multiplies streaming operands, accumulates locally, forwards operands right/down.
// - Mode 1 (drain): shifts accumulated results out through a c_in -> c_out chain to the array edge.
// - Instantiated in a 2-D grid: a_out feeds the right neighbour, b_out the lower one, c_out the next drain stage.

---
 rtl/processing_element.sv | 75 +++++++
 tb/tb_processing_element.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/processing_element.sv
// Output-stationary 8-bit MAC cell: accumulates a_in*b_in in mode 0, shifts acc down the c-chain in mode 1.
// Optional build macro PE_SATURATE_EN selects saturating accumulation instead of modulo-256 wrap.
module processing_element (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic [7:0] c_in,
  output logic [7:0] a_out,
  output logic [7:0] b_out,
  output logic [7:0] c_out
);

  logic [7:0] acc_q, acc_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] c_q, c_d;
  logic [7:0] mac_lo;

`ifdef PE_SATURATE_EN
  logic [15:0] prod_full;
  logic [8:0]  sat_sum;

  always_comb begin
    prod_full = 16'(a_in) * 16'(b_in);
    sat_sum   = {1'b0, acc_q} + {1'b0, prod_full[7:0]};
    // Any product above one byte already overflows, regardless of acc.
    if ((prod_full[15:8] != 8'h00) || sat_sum[8]) begin
      mac_lo = '1;
    end else begin
      mac_lo = sat_sum[7:0];
    end
  end
`else
  logic [7:0] prod_lo;

  always_comb begin
    prod_lo = a_in * b_in;
    mac_lo  = acc_q + prod_lo;
  end
`endif

  always_comb begin
    a_d   = a_in;
    b_d   = b_in;
    acc_d = acc_q;
    c_d   = c_q;
    if (mode) begin
      c_d   = acc_q;
      acc_d = c_in;
    end else begin
      acc_d = mac_lo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
    end else begin
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign c_out = c_q;

endmodule

// File: tb/tb_processing_element.sv
// Directed self-checking bench for processing_element; expectations follow the build's PE_SATURATE_EN setting.
module tb_processing_element;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [7:0] a_in, b_in, c_in;
  logic [7:0] a_out, b_out, c_out;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

`ifdef PE_SATURATE_EN
  localparam logic [7:0] EXP_ACC1 = 8'hFF, EXP_ACC2 = 8'hFF, EXP_ACC3 = 8'hFF;
  localparam logic [7:0] EXP_WRAP = 8'hFF, EXP_ZP   = 8'hFF;
`else
  localparam logic [7:0] EXP_ACC1 = 8'h23, EXP_ACC2 = 8'h3B, EXP_ACC3 = 8'h54;
  localparam logic [7:0] EXP_WRAP = 8'h03, EXP_ZP   = 8'h02;
`endif

  processing_element dut (
    .clk(clk), .rst(rst), .mode(mode),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .a_out(a_out), .b_out(b_out), .c_out(c_out)
  );

  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, return at the following falling edge.
  task automatic step(input logic m, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    mode = m; a_in = a; b_in = b; c_in = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(1'b0, 8'h05, 8'h07, 8'h09);
    step(1'b1, 8'h05, 8'h07, 8'h09);
    #1;
    a_in = 8'($urandom); b_in = 8'($urandom); c_in = 8'($urandom); mode = 1'($urandom);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({a_out, b_out, c_out} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_async a/b/c_out=%h/%h/%h required 00/00/00", a_out, b_out, c_out);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_in = 8'($urandom); b_in = 8'($urandom); c_in = 8'($urandom); mode = 1'($urandom);
      n_tests++;
      if ({a_out, b_out, c_out} !== 24'h0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d] a/b/c_out=%h/%h/%h required 00/00/00", i, a_out, b_out, c_out);
      end
    end
    rst = 1'b0;
    step(1'b1, 8'h00, 8'h00, 8'h00);
    n_tests++;
    if (c_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_acc_clear c_out=%h required 00", c_out);
    end
  endtask

  task automatic test_compute();
    logic [7:0] av [4] = '{8'h75, 8'h12, 8'h95, 8'h00};
    logic [7:0] bv [4] = '{8'h37, 8'h2C, 8'h75, 8'h00};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, av[i], bv[i], 8'h04);
      n_tests++;
      if (a_out !== av[i] || b_out !== bv[i] || c_out !== 8'h00) begin
        n_fail++;
        $display("FAIL compute_fwd[%0d] a/b/c_out=%h/%h/%h required %h/%h/00", i, a_out, b_out, c_out, av[i], bv[i]);
      end
    end
  endtask

  task automatic test_drain();
    step(1'b1, 8'h00, 8'h00, 8'h04);
    n_tests++;
    if (c_out !== EXP_ACC3) begin
      n_fail++;
      $display("FAIL drain_first c_out=%h required %h", c_out, EXP_ACC3);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h00, 8'h00, 8'h04);
      n_tests++;
      if (c_out !== 8'h04) begin
        n_fail++;
        $display("FAIL drain_chain[%0d] c_out=%h required 04", i, c_out);
      end
    end
  endtask

  task automatic test_recompute();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 8'h00, 8'hAA);
      n_tests++;
      if (c_out !== 8'h04) begin
        n_fail++;
        $display("FAIL recompute_hold[%0d] c_out=%h required 04", i, c_out);
      end
    end
    step(1'b1, 8'h00, 8'h00, 8'h00);
    n_tests++;
    if (c_out !== 8'h04) begin
      n_fail++;
      $display("FAIL recompute_acc c_out=%h required 04", c_out);
    end
  endtask

  // Partial sums observed by draining after 1 and 2 operand pairs.
  task automatic test_partial();
    do_reset();
    step(1'b0, 8'h75, 8'h37, 8'h00);
    step(1'b1, 8'h00, 8'h00, 8'h00);
    n_tests++;
    if (c_out !== EXP_ACC1) begin
      n_fail++;
      $display("FAIL partial_1 c_out=%h required %h", c_out, EXP_ACC1);
    end
    do_reset();
    step(1'b0, 8'h75, 8'h37, 8'h00);
    step(1'b0, 8'h12, 8'h2C, 8'h00);
    step(1'b1, 8'h00, 8'h00, 8'h00);
    n_tests++;
    if (c_out !== EXP_ACC2) begin
      n_fail++;
      $display("FAIL partial_2 c_out=%h required %h", c_out, EXP_ACC2);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 8'hFF, 8'hFF, 8'h00);
    step(1'b1, 8'h00, 8'h00, 8'h00);
    n_tests++;
    if (c_out !== EXP_WRAP) begin
      n_fail++;
      $display("FAIL wrap_ffxff c_out=%h required %h", c_out, EXP_WRAP);
    end
    do_reset();
    for (int i = 0; i < 2; i++) step(1'b0, 8'hFF, 8'hFF, 8'h00);
    for (int i = 0; i < 2; i++) step(1'b0, 8'h10, 8'h10, 8'h00);
    step(1'b1, 8'h00, 8'h00, 8'h00);
    n_tests++;
    if (c_out !== EXP_ZP) begin
      n_fail++;
      $display("FAIL wrap_10x10 c_out=%h required %h", c_out, EXP_ZP);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b0, 8'h03, 8'h04, 8'h00);
    step(1'b1, 8'h00, 8'h00, 8'h04);
    n_tests++;
    if (c_out !== 8'h0C) begin
      n_fail++;
      $display("FAIL b2b_drain c_out=%h required 0c", c_out);
    end
    step(1'b0, 8'h02, 8'h03, 8'h00);
    n_tests++;
    if (c_out !== 8'h0C || a_out !== 8'h02 || b_out !== 8'h03) begin
      n_fail++;
      $display("FAIL b2b_compute a/b/c_out=%h/%h/%h required 02/03/0c", a_out, b_out, c_out);
    end
    step(1'b1, 8'h00, 8'h00, 8'h00);
    n_tests++;
    if (c_out !== 8'h0A) begin
      n_fail++;
      $display("FAIL b2b_resume c_out=%h required 0a", c_out);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    step(1'b0, 8'h03, 8'h05, 8'h00);
    step(1'b1, 8'h00, 8'h00, 8'h07);
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({a_out, b_out, c_out} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_mid_drain a/b/c_out=%h/%h/%h required 00/00/00", a_out, b_out, c_out);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h00, 8'h00, 8'h00);
    n_tests++;
    if (c_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_drain_acc c_out=%h required 00", c_out);
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; a_in = '0; b_in = '0; c_in = '0;
    @(negedge clk);
    test_reset();
    test_compute();
    test_drain();
    test_recompute();
    test_partial();
    test_wrap();
    test_back_to_back();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
